mul_dot_accumulator: RTL and testbench

- Downstream consumer of the signed add-shift multiplier.
- Captures each finished signed product and sign-extends it. Accumulates LEN consecutive products into one dot-product result.
- Presents the result with a valid/ack handshake.
- Drives in_ready so the upstream sequencer only pulses the multiplier start when the next product can be accepted.

---
 rtl/mul_dot_accumulator.sv | 152 +++++++++++++++
 tb/tb_mul_dot_accumulator.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_dot_accumulator.sv
// Dot-product accumulator behind a signed add-shift multiplier.
// It sums LEN products and hands the result off through a valid/ack handshake.
// Define MUL_DOT_ACC_SAT_EN to saturate the accumulator on overflow; otherwise it wraps.
module mul_dot_accumulator #(
    parameter int P      = 8,
    parameter int ACC_W  = 9,
    parameter int LEN    = 4,
    parameter int logLEN = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [P-1:0]      prod_in,
    input  logic              prod_valid,
    input  logic              acc_ack,
    output logic              in_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    output logic              acc_ovf,
    output logic              drop,
    output logic [logLEN-1:0] cnt
);

    typedef enum logic [1:0] {StIdle, StAccum, StFull} state_e;

    localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [logLEN-1:0] LenCnt = logLEN'(LEN);

    state_e            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [logLEN-1:0] cnt_q, cnt_d;
    logic              ovf_acc_q, ovf_acc_d;
    logic [ACC_W-1:0]  acc_out_q, acc_out_d;
    logic              acc_valid_q, acc_valid_d;
    logic              acc_ovf_q, acc_ovf_d;
    logic              drop_q, drop_d;
    logic              prod_valid_q;

    logic              prod_edge;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  sum_raw;
    logic [ACC_W-1:0]  sum;
    logic              ovf_this;
    logic [logLEN-1:0] cnt_inc;
    logic              group_done;

    assign prod_edge = prod_valid & ~prod_valid_q;
    assign prod_ext  = ACC_W'($signed(prod_in));
    assign sum_raw   = acc_q + prod_ext;
    assign ovf_this  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                       (sum_raw[ACC_W-1] != acc_q[ACC_W-1]);
    assign cnt_inc   = cnt_q + 1'b1;
    assign group_done = (cnt_inc == LenCnt);

    // Both operands share a sign on overflow, so the accumulator's sign picks the clamp rail.
    always_comb begin
        sum = sum_raw;
`ifdef MUL_DOT_ACC_SAT_EN
        if (ovf_this) begin
            sum = acc_q[ACC_W-1] ? AccMin : AccMax;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_acc_d   = ovf_acc_q;
        acc_out_d   = acc_out_q;
        acc_valid_d = acc_valid_q;
        acc_ovf_d   = acc_ovf_q;
        drop_d      = drop_q;

        if (clr) begin
            state_d     = StIdle;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_acc_d   = 1'b0;
            acc_valid_d = 1'b0;
            drop_d      = 1'b0;
        end else begin
            case (state_q)
                // acc is always zero in StIdle, so sum equals the sign-extended product there.
                StIdle, StAccum: begin
                    if (prod_edge) begin
                        if (group_done) begin
                            acc_out_d   = sum;
                            acc_ovf_d   = ovf_acc_q | ovf_this;
                            acc_valid_d = 1'b1;
                            acc_d       = '0;
                            cnt_d       = '0;
                            ovf_acc_d   = 1'b0;
                            state_d     = StFull;
                        end else begin
                            acc_d     = sum;
                            cnt_d     = cnt_inc;
                            ovf_acc_d = ovf_acc_q | ovf_this;
                            state_d   = StAccum;
                        end
                    end
                end
                StFull: begin
                    if (prod_edge) begin
                        drop_d = 1'b1;
                    end
                    if (acc_ack) begin
                        acc_valid_d = 1'b0;
                        state_d     = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_acc_q    <= 1'b0;
            acc_out_q    <= '0;
            acc_valid_q  <= 1'b0;
            acc_ovf_q    <= 1'b0;
            drop_q       <= 1'b0;
            // A done level that is already high when reset is released must not count as an edge.
            prod_valid_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            ovf_acc_q    <= ovf_acc_d;
            acc_out_q    <= acc_out_d;
            acc_valid_q  <= acc_valid_d;
            acc_ovf_q    <= acc_ovf_d;
            drop_q       <= drop_d;
            prod_valid_q <= prod_valid;
        end
    end

    assign in_ready  = (state_q != StFull);
    assign acc_out   = acc_out_q;
    assign acc_valid = acc_valid_q;
    assign acc_ovf   = acc_ovf_q;
    assign drop      = drop_q;
    assign cnt       = cnt_q;

endmodule

// File: tb/tb_mul_dot_accumulator.sv
// Self-checking bench for mul_dot_accumulator: directed scenarios plus randomized groups
// checked against an integer reference model.
module tb_mul_dot_accumulator;

    localparam int P      = 8;
    localparam int ACC_W  = 9;
    localparam int LEN    = 4;
    localparam int LOGLEN = 3;
    localparam int MAXV   = 2 ** (ACC_W - 1) - 1;
    localparam int MINV   = -(2 ** (ACC_W - 1));
`ifdef MUL_DOT_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clr = 1'b0;
    logic [P-1:0]      prod_in = '0;
    logic              prod_valid = 1'b0;
    logic              acc_ack = 1'b0;
    logic              in_ready;
    logic [ACC_W-1:0]  acc_out;
    logic              acc_valid;
    logic              acc_ovf;
    logic              drop;
    logic [LOGLEN-1:0] cnt;

    int total = 0;
    int bad   = 0;

    mul_dot_accumulator #(
        .P     (P),
        .ACC_W (ACC_W),
        .LEN   (LEN),
        .logLEN(LOGLEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .prod_in   (prod_in),
        .prod_valid(prod_valid),
        .acc_ack   (acc_ack),
        .in_ready  (in_ready),
        .acc_out   (acc_out),
        .acc_valid (acc_valid),
        .acc_ovf   (acc_ovf),
        .drop      (drop),
        .cnt       (cnt)
    );

    always #5 clk = ~clk;

    // Exact integer running sum; any step leaving the signed range flags overflow
    // and then wraps or clamps.
    function automatic void model_group(input int prods[$], output int res, output bit ovf);
        int acc;
        int n;
        acc = 0;
        ovf = 1'b0;
        foreach (prods[i]) begin
            n = acc + prods[i];
            if (n > MAXV || n < MINV) begin
                ovf = 1'b1;
                if (SAT) n = (n > MAXV) ? MAXV : MINV;
                else     n = (n > MAXV) ? n - 2 ** ACC_W : n + 2 ** ACC_W;
            end
            acc = n;
        end
        res = acc;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int p);
        prod_in    = P'(p);
        prod_valid = 1'b1;
        tick();
        prod_valid = 1'b0;
        tick();
    endtask

    task automatic run_group(input int prods[$]);
        foreach (prods[i]) pulse(prods[i]);
    endtask

    task automatic ack();
        acc_ack = 1'b1;
        tick();
        acc_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        prod_valid = 1'b1;
        prod_in    = 8'd5;
        repeat (10) tick();
        rst = 1'b0;
        tick();
        total++; if (cnt !== 0) begin bad++; $display("FAIL reset_held_level cnt got=%0d want=0", cnt); end
        prod_valid = 1'b0;
        tick();
        total++; if (acc_out !== 0) begin bad++; $display("FAIL reset_acc_out got=%0d want=0", acc_out); end
        total++; if (acc_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", acc_valid); end
        total++; if (acc_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", acc_ovf); end
        total++; if (drop !== 1'b0) begin bad++; $display("FAIL reset_drop got=%b want=0", drop); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_basic();
        int prods[$] = '{10, 20, -5, 7};
        for (int i = 0; i < 3; i++) begin
            pulse(prods[i]);
            total++; if (cnt !== LOGLEN'(i + 1)) begin bad++; $display("FAIL basic_cnt got=%0d want=%0d", cnt, i + 1); end
            total++; if (acc_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b want=0", acc_valid); end
        end
        prod_in    = P'(prods[3]);
        prod_valid = 1'b1;
        tick();
        total++; if (acc_valid !== 1'b1) begin bad++; $display("FAIL basic_latency got=%b want=1", acc_valid); end
        total++; if ($signed(acc_out) !== 32) begin bad++; $display("FAIL basic_out got=%0d want=32", $signed(acc_out)); end
        total++; if (acc_ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b want=0", acc_ovf); end
        prod_valid = 1'b0;
        repeat (3) tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_full got=%b want=0", in_ready); end
        total++; if (acc_valid !== 1'b1) begin bad++; $display("FAIL basic_valid_held got=%b want=1", acc_valid); end
        ack();
        total++; if (acc_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_ack got=%b want=0", acc_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_ack got=%b want=1", in_ready); end
        total++; if (cnt !== 0) begin bad++; $display("FAIL basic_cnt_ack got=%0d want=0", cnt); end
    endtask

    task automatic test_held_level();
        prod_in    = 8'd3;
        prod_valid = 1'b1;
        repeat (5) tick();
        prod_valid = 1'b0;
        tick();
        total++; if (cnt !== 1) begin bad++; $display("FAIL held_cnt got=%0d want=1", cnt); end
        run_group('{3, 3, 3});
        total++; if ($signed(acc_out) !== 12) begin bad++; $display("FAIL held_out got=%0d want=12", $signed(acc_out)); end
        ack();
    endtask

    task automatic test_overflow(input int p, input string name);
        int prods[$];
        int res;
        bit ovf;
        prods = '{p, p, p, p};
        model_group(prods, res, ovf);
        run_group(prods);
        total++; if (acc_out !== ACC_W'(res)) begin bad++; $display("FAIL %s_out got=%0d want=%0d", name, $signed(acc_out), res); end
        total++; if (acc_ovf !== ovf) begin bad++; $display("FAIL %s_ovf got=%b want=%b", name, acc_ovf, ovf); end
        ack();
    endtask

    task automatic test_backpressure();
        run_group('{1, 2, 3, 4});
        pulse(99);
        pulse(77);
        total++; if (drop !== 1'b1) begin bad++; $display("FAIL bp_drop got=%b want=1", drop); end
        total++; if ($signed(acc_out) !== 10) begin bad++; $display("FAIL bp_out_held got=%0d want=10", $signed(acc_out)); end
        total++; if (acc_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b want=1", acc_valid); end
        total++; if (cnt !== 0) begin bad++; $display("FAIL bp_cnt got=%0d want=0", cnt); end
        ack();
        run_group('{5, 5, 5, 5});
        total++; if ($signed(acc_out) !== 20) begin bad++; $display("FAIL bp_next_out got=%0d want=20", $signed(acc_out)); end
        total++; if (drop !== 1'b1) begin bad++; $display("FAIL bp_drop_sticky got=%b want=1", drop); end
        ack();
    endtask

    task automatic test_abort();
        run_group('{50, 60});
        total++; if (cnt !== 2) begin bad++; $display("FAIL abort_pre_cnt got=%0d want=2", cnt); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total++; if (cnt !== 0) begin bad++; $display("FAIL abort_cnt got=%0d want=0", cnt); end
        total++; if (drop !== 1'b0) begin bad++; $display("FAIL abort_drop got=%b want=0", drop); end
        total++; if ($signed(acc_out) !== 20) begin bad++; $display("FAIL abort_out_kept got=%0d want=20", $signed(acc_out)); end
        // A product edge coinciding with clr is discarded.
        clr        = 1'b1;
        prod_in    = 8'd9;
        prod_valid = 1'b1;
        tick();
        clr        = 1'b0;
        prod_valid = 1'b0;
        tick();
        total++; if (cnt !== 0) begin bad++; $display("FAIL abort_edge_cnt got=%0d want=0", cnt); end
        run_group('{1, 1, 1, 1});
        total++; if ($signed(acc_out) !== 4) begin bad++; $display("FAIL abort_out got=%0d want=4", $signed(acc_out)); end
        total++; if (acc_ovf !== 1'b0) begin bad++; $display("FAIL abort_ovf got=%b want=0", acc_ovf); end
        ack();
    endtask

    task automatic test_rst_mid();
        run_group('{127, 127, 127, 127});
        pulse(1);
        ack();
        pulse(33);
        rst = 1'b1;
        tick();
        total++; if (cnt !== 0) begin bad++; $display("FAIL rstmid_cnt got=%0d want=0", cnt); end
        total++; if (acc_out !== 0) begin bad++; $display("FAIL rstmid_out got=%0d want=0", acc_out); end
        total++; if (acc_ovf !== 1'b0) begin bad++; $display("FAIL rstmid_ovf got=%b want=0", acc_ovf); end
        total++; if (drop !== 1'b0) begin bad++; $display("FAIL rstmid_drop got=%b want=0", drop); end
        total++; if (acc_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL rstmid_hs got=%b/%b want=0/1", acc_valid, in_ready);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int g = 0; g < 25; g++) begin
            int prods[$];
            int res;
            bit ovf;
            logic signed [P-1:0] b;
            prods = {};
            for (int i = 0; i < LEN; i++) begin
                b = P'($urandom);
                if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) == 1) ? 8'sd127 : -8'sd128;
                prods.push_back(int'(b));
            end
            model_group(prods, res, ovf);
            foreach (prods[i]) begin
                pulse(prods[i]);
                repeat ($urandom_range(0, 2)) tick();
            end
            for (int k = 0; k < 8 && acc_valid !== 1'b1; k++) tick();
            total++; if (acc_valid !== 1'b1) begin bad++; $display("FAIL rand_valid grp=%0d got=%b want=1", g, acc_valid); end
            total++; if (acc_out !== ACC_W'(res)) begin bad++; $display("FAIL rand_out grp=%0d got=%0d want=%0d", g, $signed(acc_out), res); end
            total++; if (acc_ovf !== ovf) begin bad++; $display("FAIL rand_ovf grp=%0d got=%b want=%b", g, acc_ovf, ovf); end
            repeat ($urandom_range(0, 3)) tick();
            ack();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_held_level();
        test_overflow(127, "posovf");
        test_overflow(-128, "negovf");
        test_backpressure();
        test_abort();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
